smi_master: RTL and testbench

Hardware SMI (MDIO) management master for the RMII Ethernet PHY. It replaces CPU bit-banging of the management port with a sequenced IEEE 802.3 clause-22 frame engine. It sits in the mclk domain next to the MAC. Its mdc/mdo/mdd outputs drive the PHY's MDC pin and MDIO tristate buffer, and mdi returns the buffered MDIO input. The CPU issues one register read or write per start pulse and polls busy or waits for done.

---
 rtl/smi_master.sv | 156 +++++++++++++++
 tb/tb_smi_master.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smi_master.sv
// smi_master: clause-22 MDIO management frame engine for the RMII PHY.
// Define SMI_POLL_EN to enable periodic link-status polling of PHY register 1.
module smi_master #(
  parameter int unsigned CLKDIV  = 20,
  parameter int unsigned POLLDIV = 20
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [4:0]  phyad,
  input  logic [4:0]  regad,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        mdc,
  output logic        mdo,
  output logic        mdd,
  input  logic        mdi,
  output logic        link,
  output logic        linkchg
);

  localparam int unsigned PW = $clog2(CLKDIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLKDIV - 1);
  localparam logic [PW-1:0] PRE_END  = PW'(CLKDIV - 2);
  localparam logic [5:0] TA_FIRST    = 6'd46;
  localparam logic [5:0] DATA_FIRST  = 6'd48;
  localparam logic [5:0] BIT_LAST    = 6'd63;

  if (CLKDIV < 2 || POLLDIV == 0) begin : g_param_check
    $error("smi_master: CLKDIV must be >= 2 and POLLDIV >= 1");
  end

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t        state;
  logic [PW-1:0] pre;
  logic [5:0]    bitcnt;
  logic [62:0]   tx;
  logic [15:0]   rx;
  logic          is_read;
  logic          is_poll;
  logic          poll_go_c;
  logic          launch_c;
  logic          frame_end_c;
  logic          wr_c;
  logic [4:0]    reg_c;
  logic [63:0]   frame_c;

  assign launch_c    = (state == S_IDLE) && (start || poll_go_c);
  // The last high phase is one cycle short so done lands exactly 128*CLKDIV after start.
  assign frame_end_c = (state == S_SHIFT) && mdc && (bitcnt == BIT_LAST) && (pre == PRE_END);

  // Outgoing frame; read frames carry ones where the PHY owns the line.
  always_comb begin
    wr_c    = start & op;
    reg_c   = start ? regad : 5'd1;
    frame_c = {32'hFFFF_FFFF, 2'b01, (wr_c ? 2'b01 : 2'b10), phyad, reg_c,
               (wr_c ? 2'b10 : 2'b11), (wr_c ? wdata : 16'hFFFF)};
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      state   <= S_IDLE;
      pre     <= '0;
      bitcnt  <= '0;
      tx      <= '0;
      rx      <= '0;
      is_read <= 1'b0;
      is_poll <= 1'b0;
      rdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      mdc     <= 1'b0;
      mdo     <= 1'b1;
      mdd     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (launch_c) begin
            state   <= S_SHIFT;
            busy    <= 1'b1;
            pre     <= '0;
            bitcnt  <= '0;
            mdc     <= 1'b0;
            mdd     <= 1'b1;
            mdo     <= frame_c[63];
            tx      <= frame_c[62:0];
            is_read <= ~wr_c;
            is_poll <= ~start;
          end
        end
        S_SHIFT: begin
          pre <= pre + PW'(1);
          if (!mdc) begin
            // Last low cycle: sample the PHY just before the rising edge.
            if (pre == PRE_LAST) begin
              pre <= '0;
              mdc <= 1'b1;
              if (bitcnt >= DATA_FIRST) rx <= {rx[14:0], mdi};
            end
          end else if (frame_end_c) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            pre    <= '0;
            bitcnt <= '0;
            mdc    <= 1'b0;
            mdd    <= 1'b0;
            mdo    <= 1'b1;
            done   <= ~is_poll;
            if (is_read && !is_poll) rdata <= rx;
          end else if (pre == PRE_LAST) begin
            pre    <= '0;
            mdc    <= 1'b0;
            bitcnt <= bitcnt + 6'd1;
            mdo    <= tx[62];
            tx     <= {tx[61:0], 1'b1};
            if (is_read && (bitcnt + 6'd1 == TA_FIRST)) mdd <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SMI_POLL_EN
  logic [POLLDIV-1:0] poll_cnt;

  assign poll_go_c = (state == S_IDLE) && !start && (&poll_cnt);

  // Interval counter runs only while idle; a CPU start always defers the poll.
  always_ff @(posedge mclk) begin
    if (reset) begin
      poll_cnt <= '0;
      link     <= 1'b0;
      linkchg  <= 1'b0;
    end else begin
      linkchg <= 1'b0;
      if (state != S_IDLE || start || poll_go_c) poll_cnt <= '0;
      else                                       poll_cnt <= poll_cnt + POLLDIV'(1);
      if (frame_end_c && is_poll) begin
        link    <= rx[2];
        linkchg <= rx[2] ^ link;
      end
    end
  end
`else
  assign poll_go_c = 1'b0;
  assign link      = 1'b0;
  assign linkchg   = 1'b0;
`endif

endmodule

// File: tb/tb_smi_master.sv
// Self-checking bench for smi_master: PHY model on MDIO, scoreboard on done/rdata.
`timescale 1ns/1ps
module tb_smi_master;

  localparam int unsigned CLKDIV  = 2;
  localparam int unsigned POLLDIV = 8;
  localparam int FRAME = 128 * CLKDIV;

  logic        mclk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [4:0]  phyad = '0;
  logic [4:0]  regad = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        busy, done, mdc, mdo, mdd, link, linkchg;
  logic        mdi = 1'b1;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int chg_cnt = 0;

  always #5 mclk = ~mclk;

  smi_master #(.CLKDIV(CLKDIV), .POLLDIV(POLLDIV)) dut (
    .mclk(mclk), .reset(reset), .start(start), .op(op), .phyad(phyad),
    .regad(regad), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .mdc(mdc), .mdo(mdo), .mdd(mdd), .mdi(mdi), .link(link), .linkchg(linkchg)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // PHY register file
  logic [15:0] phy_bmsr = 16'h7809;
  function automatic logic [15:0] phy_reg(input logic [4:0] ra);
    case (ra)
      5'd1:    return phy_bmsr;
      5'd2:    return 16'h0022;
      default: return {11'h5A5, ra};
    endcase
  endfunction

  // PHY model: decodes a read header from mdo, then drives data after each rising mdc
  logic [45:0] phy_win = '0;
  logic [15:0] phy_data = '0;
  int          phy_pos = -1;
  always @(posedge mdc) begin
    if (mdd) begin
      phy_win = {phy_win[44:0], mdo};
      if (phy_win[45:14] == 32'hFFFF_FFFF && phy_win[13:10] == 4'b0110) begin
        phy_pos  = 45;
        phy_data = phy_reg(phy_win[4:0]);
      end else begin
        phy_pos = -1;
      end
    end else if (phy_pos >= 0 && phy_pos < 63) begin
      phy_pos = phy_pos + 1;
    end else begin
      phy_pos = -1;
    end
    mdi = (phy_pos >= 47 && phy_pos < 63) ? phy_data[62 - phy_pos] : 1'b1;
  end

  typedef struct {
    logic        is_read;
    logic [15:0] rd;
  } exp_t;
  exp_t sb_q[$];

  // Scoreboard: every done must match an issued CPU frame
  always @(negedge mclk) begin
    exp_t e;
    if (!reset && done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        chk("spurious_done", 64'(done), 64'd0);
      end else begin
        e = sb_q.pop_front();
        if (e.is_read) chk("rdata", 64'(rdata), 64'(e.rd));
      end
    end
    if (linkchg) chg_cnt++;
  end

  task automatic tick();
    @(posedge mclk);
    @(negedge mclk);
  endtask

  task automatic start_frame(input logic o, input logic [4:0] pa, input logic [4:0] ra,
                             input logic [15:0] wd);
    exp_t e;
    int   n;
    n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
    chk("start_wait", 64'(busy), 64'd0);
    start = 1'b1;
    op    = o;
    phyad = pa;
    regad = ra;
    wdata = wd;
    e.is_read = ~o;
    e.rd      = phy_reg(ra);
    sb_q.push_back(e);
  endtask

  // Walks one frame from the start cycle to the done cycle, checking line activity
  task automatic walk_frame(input logic [63:0] exp_mdo, input logic [63:0] mask,
                            input logic [63:0] exp_mdd, input int inject_bit,
                            input int abort_bit);
    logic [63:0] got_mdo;
    logic [63:0] got_mdd;
    int          mdc_err;
    got_mdo = '0;
    got_mdd = '0;
    mdc_err = 0;
    for (int o = 1; o <= FRAME; o++) begin
      int b;
      int p;
      tick();
      start = 1'b0;
      b = (o - 1) / (2 * CLKDIV);
      p = (o - 1) % (2 * CLKDIV);
      if (o == 1) chk("busy_rise", 64'(busy), 64'd1);
      if (b == abort_bit && p == 0) begin
        reset = 1'b1;
        return;
      end
      if (b == inject_bit && p == 0) begin
        start = 1'b1;
        op    = ~op;
        regad = 5'd7;
      end
      if (o < FRAME) begin
        if (mdc !== (p >= int'(CLKDIV))) mdc_err++;
        if (p == 0) begin
          got_mdo[63 - b] = mdo;
          got_mdd[63 - b] = mdd;
        end
      end
      if (o == FRAME - 1) begin
        chk("busy_last", 64'(busy), 64'd1);
        chk("done_early", 64'(done), 64'd0);
      end
    end
    chk("mdo_seq", got_mdo & mask, exp_mdo & mask);
    chk("mdd_seq", got_mdd, exp_mdd);
    chk("mdc_shape", 64'(mdc_err), 64'd0);
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_end", 64'(busy), 64'd0);
    chk("mdd_end", 64'(mdd), 64'd0);
    chk("mdo_end", 64'(mdo), 64'd1);
  endtask

  localparam logic [63:0] ALL1   = '1;
  localparam logic [63:0] RD_MDD = {{46{1'b1}}, 18'h0};

  initial begin
    int d0;
    int c0;
    int n;
    logic any_busy, any_link, any_chg;

    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_mdc", 64'(mdc), 64'd0);
    chk("rst_mdd", 64'(mdd), 64'd0);
    chk("rst_mdo", 64'(mdo), 64'd1);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_link", 64'(link), 64'd0);
    reset = 1'b0;
    tick();

    // Write 0x3100 to PHY 1 reg 0
    start_frame(1'b1, 5'd1, 5'd0, 16'h3100);
    walk_frame({32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h3100}, ALL1, ALL1, -1, -1);
    tick();

    // Read PHY 1 reg 2
    start_frame(1'b0, 5'd1, 5'd2, 16'h0);
    walk_frame({32'hFFFF_FFFF, 2'b01, 2'b10, 5'd1, 5'd2, 18'h0}, RD_MDD, RD_MDD, -1, -1);
    chk("rdata_read2", 64'(rdata), 64'h0022);
    tick();

    // Start during an active frame is dropped
    d0 = done_cnt;
    start_frame(1'b1, 5'd3, 5'd4, 16'hA55A);
    walk_frame({32'hFFFF_FFFF, 2'b01, 2'b01, 5'd3, 5'd4, 2'b10, 16'hA55A}, ALL1, ALL1, 10, -1);
    repeat (FRAME + 20) tick();
    chk("single_done", 64'(done_cnt - d0), 64'd1);

    // Back-to-back: write then read started in the done cycle
    d0 = done_cnt;
    start_frame(1'b1, 5'd2, 5'd9, 16'h0F0F);
    walk_frame({32'hFFFF_FFFF, 2'b01, 2'b01, 5'd2, 5'd9, 2'b10, 16'h0F0F}, ALL1, ALL1, -1, -1);
    start_frame(1'b0, 5'd2, 5'd5, 16'h0);
    walk_frame({32'hFFFF_FFFF, 2'b01, 2'b10, 5'd2, 5'd5, 18'h0}, RD_MDD, RD_MDD, -1, -1);
    chk("rdata_read5", 64'(rdata), 64'({11'h5A5, 5'd5}));
    tick();
    chk("b2b_dones", 64'(done_cnt - d0), 64'd2);

    // Reset in the middle of a frame
    d0 = done_cnt;
    start_frame(1'b1, 5'd1, 5'd0, 16'h1234);
    walk_frame(ALL1, ALL1, ALL1, -1, 40);
    tick();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_mdc", 64'(mdc), 64'd0);
    chk("abort_mdd", 64'(mdd), 64'd0);
    chk("abort_mdo", 64'(mdo), 64'd1);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_rdata", 64'(rdata), 64'd0);
    reset = 1'b0;
    sb_q.delete();
    repeat (FRAME + 20) tick();
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);

    // Read reg 2 again so rdata holds a known value
    start_frame(1'b0, 5'd1, 5'd2, 16'h0);
    walk_frame({32'hFFFF_FFFF, 2'b01, 2'b10, 5'd1, 5'd2, 18'h0}, RD_MDD, RD_MDD, -1, -1);
    tick();

`ifdef SMI_POLL_EN
    d0 = done_cnt;
    c0 = chg_cnt;
    repeat (700) tick();
    chk("link_low", 64'(link), 64'd0);
    chk("no_chg_low", 64'(chg_cnt - c0), 64'd0);
    phy_bmsr[2] = 1'b1;
    n = 0;
    while (chg_cnt == c0 && n < 2000) begin
      tick();
      n++;
    end
    chk("link_high", 64'(link), 64'd1);
    repeat (1200) tick();
    chk("chg_single", 64'(chg_cnt - c0), 64'd1);
    chk("link_hold", 64'(link), 64'd1);
    chk("poll_no_done", 64'(done_cnt - d0), 64'd0);
    chk("poll_rdata", 64'(rdata), 64'h0022);
`else
    for (int blk = 0; blk < 10; blk++) begin
      any_busy = 1'b0;
      any_link = 1'b0;
      any_chg  = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        tick();
        any_busy |= busy;
        any_link |= link;
        any_chg  |= linkchg;
      end
      chk("idle_busy", 64'(any_busy), 64'd0);
      chk("idle_link", 64'(any_link), 64'd0);
      chk("idle_linkchg", 64'(any_chg), 64'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
